// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between a command source and alu_sequencer.
// The slave modport is the sequencer side; the master modport is the requester side.
interface alu_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [3:0] cmd_op;
  logic [7:0] cmd_b;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Accumulator-based sequencer for an external 8-bit combinational ALU: accepts one
// command, holds ALU inputs stable, captures the result and returns it with flags.
module alu_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus,
  output logic [7:0]       alu_a_o,
  output logic [7:0]       alu_b_o,
  output logic [3:0]       alu_sel_o,
  input  logic [8:0]       alu_result_i,
  output logic [7:0]       acc_o,
  output logic [CNT_W-1:0] op_count_o
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e           state_q;
  logic             settled_q;
  logic             cmd_load_q;
  logic             cmd_ready_q;
  logic [7:0]       acc_q;
  logic [7:0]       alu_a_q;
  logic [7:0]       alu_b_q;
  logic [3:0]       alu_sel_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_data_q;
  logic             rsp_carry_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;
  logic [CNT_W-1:0] op_count_q;

  logic [7:0]       rsp_data_d;
  logic             rsp_carry_d;
  logic             rsp_zero_d;
  logic             rsp_err_d;

  // Response decode from the latched command and the ALU result; only sampled in EXEC.
  always_comb begin
    rsp_err_d   = 1'b0;
    rsp_carry_d = 1'b0;
    rsp_data_d  = alu_result_i[7:0];
    if (cmd_load_q) begin
      rsp_data_d = alu_b_q;
    end else if ((alu_sel_q == OP_MUL) || ((alu_sel_q == OP_DIV) && (alu_b_q == '0))) begin
      rsp_err_d  = 1'b1;
      rsp_data_d = '0;
    end else if ((alu_sel_q == OP_ADD) || (alu_sel_q == OP_SUB) || (alu_sel_q == OP_SHL)) begin
      rsp_carry_d = alu_result_i[8];
    end
    rsp_zero_d = (rsp_data_d == '0);
  end

  // EXEC spans two cycles: the first lets the freshly registered ALU inputs settle,
  // the second is the full stable cycle whose closing edge captures the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      settled_q   <= 1'b0;
      cmd_load_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      acc_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_load_q  <= bus.cmd_load;
            alu_a_q     <= acc_q;
            alu_b_q     <= bus.cmd_b;
            alu_sel_q   <= bus.cmd_op;
            cmd_ready_q <= 1'b0;
            settled_q   <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          if (!settled_q) begin
            settled_q <= 1'b1;
          end else begin
            settled_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
            if (!rsp_err_d) begin
              acc_q      <= rsp_data_d;
              op_count_q <= op_count_q + CNT_W'(1);
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;

  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;
  assign alu_sel_o  = alu_sel_q;
  assign acc_o      = acc_q;
  assign op_count_o = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small combinational ALU model on its ALU port.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [8:0]  alu_result;
  logic [7:0]  acc;
  logic [15:0] op_count;

  int unsigned errors;
  int unsigned checks;
  logic [7:0]  model_acc;
  logic [15:0] model_cnt;

  alu_sequencer_if bus ();

  alu_sequencer #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_sel_o    (alu_sel),
    .alu_result_i (alu_result),
    .acc_o        (acc),
    .op_count_o   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: add, sub, mul, div, shl, not (inverting, sets bit 8), and, lt, eq.
  always_comb begin
    alu_result = '0;
    case (alu_sel)
      4'b0000: alu_result = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: alu_result = {1'b0, alu_a} - {1'b0, alu_b};
      4'b0010: alu_result = {1'b0, alu_a * alu_b};
      4'b0011: alu_result = (alu_b == 8'h00) ? 9'h1FF : {1'b0, alu_a / alu_b};
      4'b0100: alu_result = {alu_a, 1'b0};
      4'b1000: alu_result = ~{1'b0, alu_a};
      4'b1011: alu_result = {1'b0, alu_a & alu_b};
      4'b1110: alu_result = {8'h00, (alu_a < alu_b)};
      4'b1111: alu_result = {8'h00, (alu_a == alu_b)};
      default: alu_result = '0;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".acc"},       32'(acc), 32'h0);
    check({tag, ".alu_a"},     32'(alu_a), 32'h0);
    check({tag, ".alu_b"},     32'(alu_b), 32'h0);
    check({tag, ".alu_sel"},   32'(alu_sel), 32'h0);
    check({tag, ".rsp_data"},  32'(bus.rsp_data), 32'h0);
    check({tag, ".op_count"},  32'(op_count), 32'h0);
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, ".rsp_carry"}, 32'(bus.rsp_carry), 32'h0);
    check({tag, ".rsp_zero"},  32'(bus.rsp_zero), 32'h0);
    check({tag, ".rsp_err"},   32'(bus.rsp_err), 32'h0);
    check({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'h1);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 20 && !bus.cmd_ready; i++) step();
    check({tag, ".ready"}, 32'(bus.cmd_ready), 32'h1);
  endtask

  task automatic do_cmd(input string tag, input logic ld, input logic [3:0] op,
                        input logic [7:0] b, input logic [7:0] ed, input logic ec,
                        input logic ez, input logic ee);
    wait_ready(tag);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_op    = op;
    bus.cmd_b     = b;
    step();
    bus.cmd_valid = 1'b0;
    check({tag, ".alu_a"},    32'(alu_a), 32'(model_acc));
    check({tag, ".alu_b"},    32'(alu_b), 32'(b));
    check({tag, ".alu_sel"},  32'(alu_sel), 32'(op));
    check({tag, ".busy"},     32'(bus.cmd_ready), 32'h0);
    check({tag, ".vld_e1"},   32'(bus.rsp_valid), 32'h0);
    step();
    check({tag, ".vld_e1b"},  32'(bus.rsp_valid), 32'h0);
    step();
    check({tag, ".vld_e2"},   32'(bus.rsp_valid), 32'h1);
    check({tag, ".data"},     32'(bus.rsp_data), 32'(ed));
    check({tag, ".carry"},    32'(bus.rsp_carry), 32'(ec));
    check({tag, ".zero"},     32'(bus.rsp_zero), 32'(ez));
    check({tag, ".err"},      32'(bus.rsp_err), 32'(ee));
    if (!ee) begin
      model_acc = ld ? b : ed;
      model_cnt = model_cnt + 16'd1;
    end
    check({tag, ".acc"},      32'(acc), 32'(model_acc));
    check({tag, ".op_count"}, 32'(op_count), 32'(model_cnt));
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check({tag, ".vld_done"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, ".rdy_done"}, 32'(bus.cmd_ready), 32'h1);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    model_acc     = 8'h00;
    model_cnt     = 16'h0000;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 4'h0;
    bus.cmd_b     = 8'h00;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_reset("reset");

    // rsp_ready while idle has no effect
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("idle_ready.vld", 32'(bus.rsp_valid), 32'h0);

    do_cmd("ld_f0",   1'b1, 4'h0, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0);
    do_cmd("add_20",  1'b0, 4'h0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0);
    do_cmd("ld_05",   1'b1, 4'h0, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0);
    do_cmd("sub_07",  1'b0, 4'h1, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0);
    do_cmd("sub_fe",  1'b0, 4'h1, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0);
    do_cmd("ld_40",   1'b1, 4'h0, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0);
    do_cmd("div_0",   1'b0, 4'h3, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    do_cmd("div_8",   1'b0, 4'h3, 8'h08, 8'h08, 1'b0, 1'b0, 1'b0);
    do_cmd("mul_3",   1'b0, 4'h2, 8'h03, 8'h00, 1'b0, 1'b1, 1'b1);
    do_cmd("ld_0f",   1'b1, 4'h0, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0);
    do_cmd("and_f0",  1'b0, 4'hB, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0);
    do_cmd("ld_81",   1'b1, 4'h0, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0);
    do_cmd("shl",     1'b0, 4'h4, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
    do_cmd("not",     1'b0, 4'h8, 8'h00, 8'hFD, 1'b0, 1'b0, 1'b0);
    do_cmd("lt_ff",   1'b0, 4'hE, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    do_cmd("eq_00",   1'b0, 4'hF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // Backpressure: response held 5 cycles with a new command waiting
    wait_ready("bp");
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b1;
    bus.cmd_op    = 4'h0;
    bus.cmd_b     = 8'h33;
    step();
    bus.cmd_load  = 1'b0;
    bus.cmd_b     = 8'h01;
    step();
    step();
    model_acc = 8'h33;
    model_cnt = model_cnt + 16'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp.vld",   32'(bus.rsp_valid), 32'h1);
      check("bp.data",  32'(bus.rsp_data), 32'h33);
      check("bp.rdy",   32'(bus.cmd_ready), 32'h0);
      check("bp.alu_b", 32'(alu_b), 32'h33);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("bp.hs_rdy",   32'(bus.cmd_ready), 32'h1);
    check("bp.hs_alu_b", 32'(alu_b), 32'h33);
    step();
    bus.cmd_valid = 1'b0;
    check("bp.acc_alu_a", 32'(alu_a), 32'h33);
    check("bp.acc_alu_b", 32'(alu_b), 32'h01);
    check("bp.acc_busy",  32'(bus.cmd_ready), 32'h0);
    step();
    step();
    check("bp2.vld",   32'(bus.rsp_valid), 32'h1);
    check("bp2.data",  32'(bus.rsp_data), 32'h34);
    check("bp2.carry", 32'(bus.rsp_carry), 32'h0);
    model_acc = 8'h34;
    model_cnt = model_cnt + 16'd1;
    check("bp2.count", 32'(op_count), 32'(model_cnt));
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Reset asserted in the middle of EXEC
    wait_ready("rst");
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 4'h0;
    bus.cmd_b     = 8'h10;
    step();
    bus.cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_exec");
    @(negedge clk);
    rst_n = 1'b1;
    model_acc = 8'h00;
    model_cnt = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_exec.no_rsp", 32'(bus.rsp_valid), 32'h0);
    end
    check("rst_exec.count", 32'(op_count), 32'h0);
    do_cmd("post_ld", 1'b1, 4'h0, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0);
    do_cmd("post_add", 1'b0, 4'h0, 8'h01, 8'h5B, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
